// File: rtl/aexm_memu_pkg.sv
// Shared constants and types for the data-memory access stage.
// Opcode decode fields, access sizes, FSM states and byte-lane selects.
package aexm_memu_pkg;

  localparam logic [5:0] OPC_LS_MASK = 6'b110000;
  localparam logic [5:0] OPC_LS_VAL  = 6'b110000;
  localparam int         OPC_ST_BIT  = 2;

  localparam logic [1:0] SZ_B   = 2'd0;
  localparam logic [1:0] SZ_H   = 2'd1;
  localparam logic [1:0] SZ_W   = 2'd2;
  localparam logic [1:0] SZ_FSL = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Big-endian lanes: byte 0 lives in [31:24].
  localparam logic [3:0] SEL_B0 = 4'h8;
  localparam logic [3:0] SEL_B1 = 4'h4;
  localparam logic [3:0] SEL_B2 = 4'h2;
  localparam logic [3:0] SEL_B3 = 4'h1;
  localparam logic [3:0] SEL_HI = 4'hC;
  localparam logic [3:0] SEL_LO = 4'h3;
  localparam logic [3:0] SEL_W  = 4'hF;

  function automatic logic [31:0] st_replicate(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      SZ_B:    st_replicate = {4{d[7:0]}};
      SZ_H:    st_replicate = {2{d[15:0]}};
      default: st_replicate = d;
    endcase
  endfunction

endpackage

// File: rtl/aexm_memu_align.sv
// Combinational lane extraction of read data, zero-extended to 32 bits.
// Unrecognised size/lane combinations yield zero.
module aexm_memu_align
  import aexm_memu_pkg::*;
(
  input  logic [3:0]  sel_i,
  input  logic [1:0]  size_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o
);

  always_comb begin
    dat_o = '0;
    case (size_i)
      SZ_B: begin
        case (sel_i)
          SEL_B0:  dat_o = {24'h0, dat_i[31:24]};
          SEL_B1:  dat_o = {24'h0, dat_i[23:16]};
          SEL_B2:  dat_o = {24'h0, dat_i[15:8]};
          SEL_B3:  dat_o = {24'h0, dat_i[7:0]};
          default: dat_o = '0;
        endcase
      end
      SZ_H: begin
        case (sel_i)
          SEL_HI:  dat_o = {16'h0, dat_i[31:16]};
          SEL_LO:  dat_o = {16'h0, dat_i[15:0]};
          default: dat_o = '0;
        endcase
      end
      SZ_W: begin
        if (sel_i == SEL_W) dat_o = dat_i;
      end
      default: dat_o = '0;
    endcase
  end

endmodule

// File: rtl/aexm_memu.sv
// Data-memory stage: one outstanding cache request, pipeline held while BUSY,
// aligned load data returned with a one-cycle rLDV strobe; optional ack timeout.
module aexm_memu
  import aexm_memu_pkg::*;
#(
  parameter int DW  = 32,
  parameter int TMO = 255
) (
  input  logic          gclk,
  input  logic          grst,
  input  logic          x_en,
  input  logic [5:0]    rOPC,
  input  logic [DW-1:0] rRESULT,
  input  logic [3:0]    rDWBSEL,
  input  logic [DW-1:0] rREGD,
  output logic          dc_stb,
  output logic          dc_we,
  output logic [DW-3:0] dc_adr,
  output logic [3:0]    dc_sel,
  output logic [DW-1:0] dc_dat_o,
  input  logic          dc_ack,
  input  logic [DW-1:0] dc_dat_i,
  output logic          mem_stall,
  output logic [DW-1:0] rDWBDI,
  output logic          rLDV,
  output logic          rMEM_ERR
);

  localparam int            CW       = (TMO > 2) ? $clog2(TMO) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'((TMO == 0) ? 0 : TMO - 1);

  state_e        state_q, state_d;
  logic [DW-3:0] adr_q, adr_d;
  logic [3:0]    sel_q, sel_d;
  logic          we_q, we_d;
  logic [1:0]    size_q, size_d;
  logic [DW-1:0] dat_q, dat_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] dwbdi_q, dwbdi_d;
  logic          ldv_q, ldv_d;
  logic          err_q, err_d;

  logic          is_ls, is_ld, is_st, is_acc;
  logic [DW-1:0] ld_aligned;
  logic          unused_ok;

  assign is_ls  = (rOPC & OPC_LS_MASK) == OPC_LS_VAL;
  assign is_ld  = is_ls & ~rOPC[OPC_ST_BIT];
  assign is_st  = is_ls &  rOPC[OPC_ST_BIT];
  assign is_acc = (is_ld | is_st) & (rOPC[1:0] != SZ_FSL);

  // Lane pick uses the captured select/size, not the live execute inputs.
  aexm_memu_align u_align (
    .sel_i  (sel_q),
    .size_i (size_q),
    .dat_i  (dc_dat_i),
    .dat_o  (ld_aligned)
  );

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    sel_d   = sel_q;
    we_d    = we_q;
    size_d  = size_q;
    dat_d   = dat_q;
    cnt_d   = cnt_q;
    dwbdi_d = dwbdi_q;
    ldv_d   = 1'b0;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (x_en && is_acc) begin
          adr_d   = rRESULT[DW-1:2];
          sel_d   = rDWBSEL;
          we_d    = is_st;
          size_d  = rOPC[1:0];
          dat_d   = st_replicate(rOPC[1:0], rREGD);
          cnt_d   = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // Ack is checked first so it wins over a timeout in the same cycle.
        if (dc_ack) begin
          state_d = ST_IDLE;
          if (!we_q) begin
            dwbdi_d = ld_aligned;
            ldv_d   = 1'b1;
          end
        end else if ((TMO != 0) && (cnt_q == TMO_LAST)) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge gclk or posedge grst) begin
    if (grst) begin
      state_q <= ST_IDLE;
      adr_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      size_q  <= '0;
      dat_q   <= '0;
      cnt_q   <= '0;
      dwbdi_q <= '0;
      ldv_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      size_q  <= size_d;
      dat_q   <= dat_d;
      cnt_q   <= cnt_d;
      dwbdi_q <= dwbdi_d;
      ldv_q   <= ldv_d;
      err_q   <= err_d;
    end
  end

  assign dc_stb    = (state_q == ST_BUSY);
  assign mem_stall = (state_q == ST_BUSY);
  assign dc_we     = we_q;
  assign dc_adr    = adr_q;
  assign dc_sel    = sel_q;
  assign dc_dat_o  = dat_q;
  assign rDWBDI    = dwbdi_q;
  assign rLDV      = ldv_q;
  assign rMEM_ERR  = err_q;

  // Byte offset is carried by rDWBSEL; opcode bit 3 does not affect access.
  assign unused_ok = ^{rRESULT[1:0], rOPC[3]};

endmodule

// File: tb/tb_aexm_memu.sv
// Directed bench for aexm_memu: vector table for single accesses plus
// hand-written sequences for reset, timeout and non-access corner cases.
module tb_aexm_memu;

  logic        gclk = 1'b0;
  logic        grst, x_en, dc_ack, t_ack;
  logic [5:0]  rOPC;
  logic [31:0] rRESULT, rREGD, dc_dat_i;
  logic [3:0]  rDWBSEL;

  logic        dc_stb, dc_we, mem_stall, rLDV, rMEM_ERR;
  logic [29:0] dc_adr;
  logic [3:0]  dc_sel;
  logic [31:0] dc_dat_o, rDWBDI;

  logic        t_stb, t_we, t_stall, t_ldv, t_err;
  logic [29:0] t_adr;
  logic [3:0]  t_sel;
  logic [31:0] t_dat_o, t_dwbdi;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 gclk = ~gclk;

  aexm_memu #(.DW(32), .TMO(255)) dut (
    .gclk(gclk), .grst(grst), .x_en(x_en), .rOPC(rOPC), .rRESULT(rRESULT),
    .rDWBSEL(rDWBSEL), .rREGD(rREGD), .dc_stb(dc_stb), .dc_we(dc_we),
    .dc_adr(dc_adr), .dc_sel(dc_sel), .dc_dat_o(dc_dat_o), .dc_ack(dc_ack),
    .dc_dat_i(dc_dat_i), .mem_stall(mem_stall), .rDWBDI(rDWBDI), .rLDV(rLDV),
    .rMEM_ERR(rMEM_ERR)
  );

  aexm_memu #(.DW(32), .TMO(4)) dut_t (
    .gclk(gclk), .grst(grst), .x_en(x_en), .rOPC(rOPC), .rRESULT(rRESULT),
    .rDWBSEL(rDWBSEL), .rREGD(rREGD), .dc_stb(t_stb), .dc_we(t_we),
    .dc_adr(t_adr), .dc_sel(t_sel), .dc_dat_o(t_dat_o), .dc_ack(t_ack),
    .dc_dat_i(dc_dat_i), .mem_stall(t_stall), .rDWBDI(t_dwbdi), .rLDV(t_ldv),
    .rMEM_ERR(t_err)
  );

  typedef struct {
    logic [5:0]  opc;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] regd;
    logic [31:0] rd;
    int          dly;
    logic [29:0] adr;
    logic        we;
    logic [31:0] dato;
    logic        ldv;
    logic [31:0] dwbdi;
  } vec_t;

  vec_t tv[11];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge gclk);
    grst = 1'b1; x_en = 1'b0; dc_ack = 1'b0; t_ack = 1'b0;
    repeat (2) @(negedge gclk);
    grst = 1'b0;
  endtask

  // Present an instruction for one cycle; returns at the negedge after the issue edge.
  task automatic issue(input logic [5:0] opc, input logic [31:0] addr,
                       input logic [3:0] sel, input logic [31:0] regd);
    rOPC = opc; rRESULT = addr; rDWBSEL = sel; rREGD = regd; x_en = 1'b1;
    @(negedge gclk);
    x_en = 1'b0; rOPC = 6'o00; rRESULT = 32'hFFFF_FFFF; rDWBSEL = 4'h0; rREGD = 32'h5A5A_5A5A;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int stall_cnt;
    int n;

    grst = 1'b1; x_en = 1'b0; dc_ack = 1'b0; t_ack = 1'b0;
    rOPC = 6'o00; rRESULT = '0; rDWBSEL = '0; rREGD = '0; dc_dat_i = '0;

    //         opc    addr          sel   regd          rd            dly adr           we   dato          ldv  dwbdi
    tv[0]  = '{6'o62, 32'h0000_1004, 4'hF, 32'h0,        32'hDEADBEEF, 1, 30'h0000_0401, 1'b0, 32'h0,        1'b1, 32'hDEADBEEF};
    tv[1]  = '{6'o60, 32'h0000_2000, 4'h8, 32'h0,        32'h11223344, 0, 30'h0000_0800, 1'b0, 32'h0,        1'b1, 32'h0000_0011};
    tv[2]  = '{6'o60, 32'h0000_2001, 4'h4, 32'h0,        32'h11223344, 0, 30'h0000_0800, 1'b0, 32'h0,        1'b1, 32'h0000_0022};
    tv[3]  = '{6'o60, 32'h0000_2002, 4'h2, 32'h0,        32'h11223344, 0, 30'h0000_0800, 1'b0, 32'h0,        1'b1, 32'h0000_0033};
    tv[4]  = '{6'o60, 32'h0000_2003, 4'h1, 32'h0,        32'h11223344, 0, 30'h0000_0800, 1'b0, 32'h0,        1'b1, 32'h0000_0044};
    tv[5]  = '{6'o65, 32'h0000_3002, 4'h3, 32'h0000ABCD, 32'h0,        0, 30'h0000_0C00, 1'b1, 32'hABCDABCD, 1'b0, 32'h0000_0044};
    tv[6]  = '{6'o61, 32'h0000_0010, 4'hC, 32'h0,        32'hCAFEF00D, 2, 30'h0000_0004, 1'b0, 32'h0,        1'b1, 32'h0000_CAFE};
    tv[7]  = '{6'o61, 32'h0000_0012, 4'h3, 32'h0,        32'hCAFEF00D, 0, 30'h0000_0004, 1'b0, 32'h0,        1'b1, 32'h0000_F00D};
    tv[8]  = '{6'o64, 32'h0000_0007, 4'h1, 32'h123456A5, 32'h0,        0, 30'h0000_0001, 1'b1, 32'hA5A5A5A5, 1'b0, 32'h0000_F00D};
    tv[9]  = '{6'o66, 32'h0000_0100, 4'hF, 32'h01020304, 32'h0,        5, 30'h0000_0040, 1'b1, 32'h01020304, 1'b0, 32'h0000_F00D};
    tv[10] = '{6'o62, 32'h8000_0008, 4'hF, 32'h0,        32'h0BADF00D, 5, 30'h2000_0002, 1'b0, 32'h0,        1'b1, 32'h0BADF00D};

    // Reset state
    repeat (2) @(negedge gclk);
    check("rst_stb",   {31'h0, dc_stb},    32'h0);
    check("rst_stall", {31'h0, mem_stall}, 32'h0);
    check("rst_we",    {31'h0, dc_we},     32'h0);
    check("rst_adr",   {2'b0, dc_adr},     32'h0);
    check("rst_sel",   {28'h0, dc_sel},    32'h0);
    check("rst_dato",  dc_dat_o,           32'h0);
    check("rst_dwbdi", rDWBDI,             32'h0);
    check("rst_ldv",   {31'h0, rLDV},      32'h0);
    check("rst_err",   {31'h0, rMEM_ERR},  32'h0);
    grst = 1'b0;
    @(negedge gclk);

    for (int i = 0; i < 11; i++) begin
      dc_dat_i = tv[i].rd;
      issue(tv[i].opc, tv[i].addr, tv[i].sel, tv[i].regd);
      check($sformatf("v%0d_stb", i),  {31'h0, dc_stb},  32'h1);
      check($sformatf("v%0d_adr", i),  {2'b0, dc_adr},   {2'b0, tv[i].adr});
      check($sformatf("v%0d_sel", i),  {28'h0, dc_sel},  {28'h0, tv[i].sel});
      check($sformatf("v%0d_we", i),   {31'h0, dc_we},   {31'h0, tv[i].we});
      check($sformatf("v%0d_dato", i), dc_dat_o,         tv[i].dato);
      stall_cnt = mem_stall ? 1 : 0;
      for (int w = 0; w < tv[i].dly; w++) begin
        @(negedge gclk);
        if (mem_stall) stall_cnt++;
        check($sformatf("v%0d_stb_hold", i), {31'h0, dc_stb}, 32'h1);
        check($sformatf("v%0d_adr_hold", i), {2'b0, dc_adr}, {2'b0, tv[i].adr});
        check($sformatf("v%0d_dato_hold", i), dc_dat_o, tv[i].dato);
      end
      dc_ack = 1'b1;
      @(negedge gclk);
      dc_ack = 1'b0;
      check($sformatf("v%0d_stb_done", i), {31'h0, dc_stb},    32'h0);
      check($sformatf("v%0d_stall_off", i), {31'h0, mem_stall}, 32'h0);
      check($sformatf("v%0d_stall_cyc", i), stall_cnt,         tv[i].dly + 1);
      check($sformatf("v%0d_ldv", i),   {31'h0, rLDV},          {31'h0, tv[i].ldv});
      check($sformatf("v%0d_dwbdi", i), rDWBDI,                 tv[i].dwbdi);
      @(negedge gclk);
      check($sformatf("v%0d_ldv_pulse", i), {31'h0, rLDV}, 32'h0);
    end
    check("no_err_after_table", {31'h0, rMEM_ERR}, 32'h0);

    // Stray ack while idle
    dc_ack = 1'b1;
    @(negedge gclk);
    dc_ack = 1'b0;
    check("idle_ack_ldv", {31'h0, rLDV},   32'h0);
    check("idle_ack_stb", {31'h0, dc_stb}, 32'h0);

    // FSL size and non-memory opcode: no access
    issue(6'o63, 32'h0000_0040, 4'hF, 32'h0);
    check("fsl_stb",   {31'h0, dc_stb},    32'h0);
    check("fsl_stall", {31'h0, mem_stall}, 32'h0);
    issue(6'o00, 32'h0000_0040, 4'hF, 32'h0);
    check("alu_stb",   {31'h0, dc_stb},    32'h0);
    check("alu_stall", {31'h0, mem_stall}, 32'h0);

    // Asynchronous reset mid-transaction
    issue(6'o62, 32'h0000_0200, 4'hF, 32'h0);
    check("arst_pre_stb", {31'h0, dc_stb}, 32'h1);
    #1 grst = 1'b1;
    #1;
    check("arst_stb",   {31'h0, dc_stb},    32'h0);
    check("arst_stall", {31'h0, mem_stall}, 32'h0);
    @(negedge gclk);
    grst = 1'b0;
    dc_ack = 1'b1;
    @(negedge gclk);
    dc_ack = 1'b0;
    check("arst_stray_ldv", {31'h0, rLDV},   32'h0);
    check("arst_stray_stb", {31'h0, dc_stb}, 32'h0);

    // Timeout with no ack (TMO=4 instance)
    do_reset();
    issue(6'o62, 32'h0000_0020, 4'hF, 32'h0);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      if (!t_stb) break;
      n++;
      @(negedge gclk);
    end
    check("tmo_busy_cycles", n, 4);
    check("tmo_err",   {31'h0, t_err},   32'h1);
    check("tmo_ldv",   {31'h0, t_ldv},   32'h0);
    check("tmo_dwbdi", t_dwbdi,          32'h0);
    check("tmo_stall", {31'h0, t_stall}, 32'h0);
    repeat (3) @(negedge gclk);
    check("tmo_err_sticky", {31'h0, t_err}, 32'h1);

    // Ack on the cycle the timeout would fire: ack wins
    do_reset();
    dc_dat_i = 32'h5566_7788;
    issue(6'o62, 32'h0000_0020, 4'hF, 32'h0);
    repeat (3) @(negedge gclk);
    check("race_stb_c4", {31'h0, t_stb}, 32'h1);
    t_ack = 1'b1;
    @(negedge gclk);
    t_ack = 1'b0;
    check("race_stb",   {31'h0, t_stb}, 32'h0);
    check("race_err",   {31'h0, t_err}, 32'h0);
    check("race_ldv",   {31'h0, t_ldv}, 32'h1);
    check("race_dwbdi", t_dwbdi,        32'h5566_7788);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/aexm_memu.md
Name: aexm_memu

Overview:
- Data-memory access stage, directly downstream of the execute unit.
- Consumes the registered execute result (effective address), the byte-lane select and the load/store opcode.
- Drives a single-outstanding request/acknowledge transaction to the data cache, holds the pipeline while the transaction is in flight, and returns lane-aligned, zero-extended load data for writeback.

Parameters:
- DW, 32, data and address width; only 32 is supported.
- TMO, 255, maximum cycles to wait for dc_ack before aborting with a bus error; 0 disables the timeout.

Ports:
- gclk  in  1  clock; all state changes on the rising edge.
- grst  in  1  reset; asynchronous, active-high.
- x_en  in  1  pipeline advance; an access is issued only in a cycle where x_en=1.
- rOPC  in  6  opcode of the instruction in execute.
- rRESULT  in  32  effective address from execute.
- rDWBSEL  in  4  byte-lane select from execute, big-endian (addr[1:0]=0 -> 4'h8).
- rREGD  in  32  store source register.
- dc_stb  out  1  request valid.
- dc_we  out  1  1 = store, 0 = load.
- dc_adr  out  30  word address, rRESULT[31:2].
- dc_sel  out  4  byte lanes.
- dc_dat_o  out  32  lane-replicated store data.
- dc_ack  in  1  one-cycle completion strobe.
- dc_dat_i  in  32  read data, valid with dc_ack.
- mem_stall  out  1  hold request to the pipeline.
- rDWBDI  out  32  aligned load result.
- rLDV  out  1  one-cycle pulse: rDWBDI is valid.
- rMEM_ERR  out  1  sticky timeout flag.

Behaviour:
- Decode: fLOAD = rOPC[5:4]==2'b11 & !rOPC[2]; fSTORE = rOPC[5:4]==2'b11 & rOPC[2].
- Size is rOPC[1:0]: 0 byte, 1 half, 2 word. Size 3 (FSL) is not an access and is ignored.
- Reset values: state IDLE, dc_stb=0, dc_we=0, dc_adr=0, dc_sel=0, dc_dat_o=0, mem_stall=0, rDWBDI=0, rLDV=0, rMEM_ERR=0, timeout counter=0.
- State machine, states IDLE / BUSY:
  - IDLE, with x_en & (fLOAD|fSTORE) & size!=3: register dc_adr, dc_sel=rDWBSEL, dc_we=fSTORE, and the store data. Next edge: dc_stb=1, mem_stall=1, state BUSY, counter cleared. Latency from issue to dc_stb is 1 cycle.
  - Store data: byte {4{rREGD[7:0]}}, half {2{rREGD[15:0]}}, word rREGD.
  - BUSY with dc_ack=1: next edge dc_stb=0, mem_stall=0, state IDLE. For loads, rDWBDI is captured from dc_dat_i and rLDV=1 for exactly one cycle. Stores never pulse rLDV. Minimum load latency: issue to rLDV = 2 cycles with zero-wait ack.
  - BUSY, no ack: counter increments. When TMO!=0 and counter==TMO-1: abort to IDLE, set rMEM_ERR=1, rLDV stays 0, rDWBDI unchanged.
- Load alignment, lane picked by the captured dc_sel:
  - Byte: 8->[31:24], 4->[23:16], 2->[15:8], 1->[7:0].
  - Half: C->[31:16], 3->[15:0].
  - Word: F->all.
  - Results are zero-extended to 32 bits.
- x_en is ignored while BUSY; there is no second issue until IDLE is reached.
- dc_ack while IDLE is ignored.
- A dc_ack arriving in the same cycle the timeout fires: ack wins, no error.
- rMEM_ERR clears only on reset.
- grst asserted mid-transaction: dc_stb and mem_stall drop immediately (asynchronously). A later stray dc_ack is ignored.
- dc_adr, dc_sel, dc_we and dc_dat_o are held stable for the whole of BUSY.

Decomposition:
- Shared package constants:
  - opcode field masks for load/store decode;
  - size codes SZ_B=0, SZ_H=1, SZ_W=2, SZ_FSL=3;
  - state encoding ST_IDLE, ST_BUSY;
  - lane select constants 4'h8/4/2/1, 4'hC/3, 4'hF.
- One natural sub-module: aexm_memu_align, purely combinational (sel, size, dc_dat_i -> aligned word); it can be reused by a future sign-extending load path.

Test Plan:
- Word load: rOPC=6'o62, rRESULT=0x00001004, rDWBSEL=F, ack 1 cycle after dc_stb with dc_dat_i=0xDEADBEEF -> dc_adr=0x00000401, rLDV pulse with rDWBDI=0xDEADBEEF, mem_stall high 2 cycles.
- Byte loads, all lanes: rOPC=6'o60, dc_dat_i=0x11223344, sel 8/4/2/1 -> rDWBDI = 0x11, 0x22, 0x33, 0x44.
- Half store: rOPC=6'o65, rREGD=0x0000ABCD, sel=3 -> dc_dat_o=0xABCDABCD, dc_we=1, rLDV never asserted.
- Wait states plus simultaneous events: ack delayed 5 cycles -> dc_stb and address stable throughout. With TMO=4 and no ack -> abort after 4 BUSY cycles, rMEM_ERR=1. With TMO=4 and ack on the 4th cycle -> no error.
- Reset mid-BUSY: grst pulsed while dc_stb=1 -> dc_stb and mem_stall go 0 without waiting for a clock edge; a following dc_ack yields no rLDV.
- FSL/non-access: rOPC=6'o63 or 6'o00 with x_en=1 -> no dc_stb, no stall.
